tanh_deriv_pla: RTL and testbench
=================================

# tanh_deriv_PLA

Backward-pass companion to the shift-based tanh PLA activation. It computes the error gradient through the activation, d = g·(1 − y²), where y is the stored forward tanh output and g is the upstream gradient. Both products are evaluated with a sequential shift-and-add multiplier to keep area small. The block sits between the activation's forward-output buffer and the preceding layer's gradient accumulator, with valid/ready handshakes on both sides.

## Interface
- W_Y, 10, width of y (signed two's complement)
- Y_I, 2, integer bits of y including sign; F_Y = W_Y − Y_I = 8 fractional bits
- W_G, 10, width of g and of out (signed two's complement)
- G_I, 4, integer bits of g including sign; F_G = W_G − G_I = 6 fractional bits
- clock  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  y/g pair valid
- in_ready  out  1  block can accept a pair; high only in IDLE
- y  in  W_Y  forward tanh output, signed Q2.8
- g  in  W_G  upstream gradient, signed Q4.6
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  downstream accepts the result
- out  out  W_G  gradient d, signed Q4.6

## Operation
- States: IDLE → SQUARE → SUB → MUL → DONE → IDLE.
- **IDLE**
  - in_ready = 1.
  - On in_valid & in_ready, capture the operands:
    - |y| clamped to 1.0 (2^F_Y), so any |y| ≥ 1.0 yields derivative 0.
    - |g| held in W_G bits (|−512| = 512 fits unsigned).
    - sign(g) registered.
  - Go to SQUARE.
- **SQUARE** (F_Y+1 = 9 cycles)
  - s = |y|·|y| by LSB-first shift-add, one multiplier bit per cycle.
  - s is unsigned, 2·(F_Y+1) bits, Q.16.
- **SUB** (1 cycle)
  - om = (2^(2F_Y) − s) >> F_Y, truncated.
  - om range 0..256, i.e. 0..1.0 in Q.8; 9 bits, never negative because of the clamp.
- **MUL** (9 cycles)
  - p = |g|·om by shift-add over the bits of om.
  - m = p >> F_Y (truncate), which rounds the magnitude toward zero.
- **DONE**
  - out = sign(g) ? −m : m; out_valid = 1.
  - Because om ≤ 1.0, |out| ≤ |g|; no saturation is required, and −512·1.0 = −512 is representable.
  - On out_ready, clear out_valid and go to IDLE.
  - out keeps its last value until the next DONE.
- in_valid outside IDLE is ignored; the upstream holds its data, since in_ready = 0 gives no accept.
- y = −2.0 (most negative) clamps to 1.0, giving out = 0.

## Timing
- Reset (resetn = 0, asynchronous): state = IDLE, out = 0, out_valid = 0, in_ready = 1, all internal registers cleared.
- Reset asserted in any state, including mid-MUL, aborts the operation. No out_valid is produced for the aborted pair.
- Latency: accept at edge E0; out_valid first high after edge E0 + 19, i.e. 2·(F_Y+1)+1 cycles.
- in_ready falls after E0 and returns high the cycle after the out_valid & out_ready handshake edge.
- Throughput: one result per 21 cycles with out_ready tied high (19 compute cycles, 1 DONE cycle, 1 IDLE cycle).
- Accepting a new pair in the same cycle as the output handshake is not supported; the DONE → IDLE transition takes one cycle.
- out and out_valid are registered; there is no combinational path from inputs to outputs.
- in_ready is decoded from the state register only, so it is independent of in_valid.

## Test plan
- Zero activation: reset, then y = 0, g = 64 (+1.0), out_ready = 1. Required: out_valid at exactly E0+19, out = 64; in_ready low during E1..E20.
- Mid-range, both signs of y: y = 128 (+0.5), g = 128 (+2.0) gives out = 96 (+1.5). Repeating with y = −128 gives out = 96.
- Negative g and rounding toward zero:
  - y = 128, g = −64 gives out = −48.
  - y = 128, g = −1 gives out = 0, not −1.
- Saturated activation:
  - y = 256 (+1.0), g = 100 gives out = 0.
  - y = −384 (−1.5) gives out = 0.
  - y = −512 with g = −512 gives out = 0.
- Backpressure and illegal input:
  - Setup: y = 0, g = −512, out_ready held low for 5 cycles after out_valid rises.
  - Required: out = −512 stable with out_valid high for those 5 cycles; a new in_valid pulse during compute is ignored; exactly one result is delivered.
- Reset mid-operation: assert resetn = 0 during cycle E12 (in MUL). Required, immediately: out = 0, out_valid = 0, in_ready = 1. After release, a new pair (y = 0, g = 5) returns out = 5 at E0+19.

Source files
------------

// File: rtl/tanh_deriv_pla.sv
// Backward pass of the shift-based tanh PLA: out = g * (1 - y*y), evaluated
// with one shared LSB-first shift-add datapath (square, then scale by |g|).
module tanh_deriv_pla #(
   parameter int W_Y = 10,
   parameter int Y_I = 2,
   parameter int W_G = 10,
   parameter int G_I = 4
) (
   input  logic           clock,
   input  logic           resetn,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W_Y-1:0] y,
   input  logic [W_G-1:0] g,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W_G-1:0] out
);

   localparam int F_Y   = W_Y - Y_I;
   localparam int A_W   = F_Y + 1;
   localparam int S_W   = 2 * A_W;
   localparam int P_W   = W_G + A_W;
   localparam int R_W   = (S_W > P_W) ? S_W : P_W;
   localparam int CNT_W = $clog2(A_W);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SQUARE = 3'd1;
   localparam logic [2:0] ST_SUB    = 3'd2;
   localparam logic [2:0] ST_MUL    = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   localparam logic [W_Y-1:0]   Y_LSB    = {{(W_Y-1){1'b0}}, 1'b1};
   localparam logic [W_G-1:0]   G_LSB    = {{(W_G-1){1'b0}}, 1'b1};
   localparam logic [A_W-1:0]   ONE_Y    = {1'b1, {F_Y{1'b0}}};
   localparam logic [R_W-1:0]   ONE_SQ   = {{(R_W-1){1'b0}}, 1'b1} << (2 * F_Y);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(A_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [R_W-1:0]   acc_q, acc_d;
   logic [R_W-1:0]   mcand_q, mcand_d;
   logic [A_W-1:0]   mplier_q, mplier_d;
   logic [W_G-1:0]   gabs_q, gabs_d;
   logic             gsign_q, gsign_d;
   logic [W_G-1:0]   out_q, out_d;
   logic             out_valid_q, out_valid_d;

   logic [W_Y-1:0] y_abs_s;
   logic [A_W-1:0] ya_s;
   logic [W_G-1:0] g_abs_s;
   logic [R_W-1:0] add_s;
   logic [R_W-1:0] diff_s;
   logic [A_W-1:0] om_s;
   logic [W_G-1:0] m_s;

   // Operand conditioning and shared shift-add datapath
   always_comb begin
      y_abs_s = y[W_Y-1] ? (~y + Y_LSB) : y;
      g_abs_s = g[W_G-1] ? (~g + G_LSB) : g;
      // any |y| >= 1.0 pins the square at 1.0 so the derivative goes to zero
      if (y_abs_s[W_Y-1:F_Y] != {(W_Y-F_Y){1'b0}}) begin
         ya_s = ONE_Y;
      end else begin
         ya_s = {1'b0, y_abs_s[F_Y-1:0]};
      end
      add_s  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      diff_s = ONE_SQ - acc_q;
      om_s   = diff_s[2*F_Y:F_Y];
      m_s    = add_s[F_Y+W_G-1:F_Y];
   end

   // Next-state and register-update logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      gabs_d      = gabs_q;
      gsign_d     = gsign_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d  = ST_SQUARE;
               cnt_d    = {CNT_W{1'b0}};
               acc_d    = {R_W{1'b0}};
               mcand_d  = {{(R_W-A_W){1'b0}}, ya_s};
               mplier_d = ya_s;
               gabs_d   = g_abs_s;
               gsign_d  = g[W_G-1];
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SQUARE, ST_MUL: begin
            acc_d    = add_s;
            mcand_d  = {mcand_q[R_W-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[A_W-1:1]};
            if (cnt_q == CNT_LAST) begin
               cnt_d = {CNT_W{1'b0}};
               if (state_q == ST_SQUARE) begin
                  state_d = ST_SUB;
               end else begin
                  state_d     = ST_DONE;
                  out_d       = gsign_q ? (~m_s + G_LSB) : m_s;
                  out_valid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_SUB: begin
            state_d  = ST_MUL;
            mplier_d = om_s;
            mcand_d  = {{(R_W-W_G){1'b0}}, gabs_q};
            acc_d    = {R_W{1'b0}};
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         acc_q       <= {R_W{1'b0}};
         mcand_q     <= {R_W{1'b0}};
         mplier_q    <= {A_W{1'b0}};
         gabs_q      <= {W_G{1'b0}};
         gsign_q     <= 1'b0;
         out_q       <= {W_G{1'b0}};
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         gabs_q      <= gabs_d;
         gsign_q     <= gsign_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = out_valid_q;
   assign out       = out_q;

endmodule

// File: tb/tb_tanh_deriv_pla.sv
// Directed self-checking bench for tanh_deriv_pla with hand-computed results.
module tb_tanh_deriv_pla;

   logic       clock;
   logic       resetn;
   logic       in_valid;
   logic       in_ready;
   logic [9:0] y;
   logic [9:0] g;
   logic       out_valid;
   logic       out_ready;
   logic [9:0] out;

   int checks_n = 0;
   int fails_n  = 0;

   tanh_deriv_pla dut (
      .clock     (clock),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .y         (y),
      .g         (g),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input int obs, input int expv);
      checks_n++;
      if (obs != expv) begin
         fails_n++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   // One transaction; hold = cycles out_ready stays low after out_valid, poke = illegal in_valid mid-compute
   task automatic do_op(input string tag, input int yv, input int gv, input int expv,
                        input int hold, input bit poke);
      int lat;
      out_ready = (hold == 0);
      y         = 10'(yv);
      g         = 10'(gv);
      in_valid  = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      lat      = 0;
      while (!out_valid && lat < 40) begin
         chk({tag, "_in_ready_busy"}, int'(in_ready), 0);
         if (poke && lat == 5) begin
            in_valid = 1'b1;
            y        = 10'd0;
            g        = 10'd7;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clock);
         #1;
         lat++;
      end
      in_valid = 1'b0;
      chk({tag, "_latency"}, lat, 19);
      chk({tag, "_out"}, int'($signed(out)), expv);
      for (int h = 0; h < hold; h++) begin
         @(posedge clock);
         #1;
         chk({tag, "_hold_valid"}, int'(out_valid), 1);
         chk({tag, "_hold_out"}, int'($signed(out)), expv);
      end
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      chk({tag, "_valid_cleared"}, int'(out_valid), 0);
      chk({tag, "_in_ready_back"}, int'(in_ready), 1);
      chk({tag, "_out_kept"}, int'($signed(out)), expv);
   endtask

   initial begin
      int extra;
      resetn    = 1'b0;
      in_valid  = 1'b0;
      y         = 10'd0;
      g         = 10'd0;
      out_ready = 1'b1;
      #22;
      chk("rst_out", int'(out), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      resetn = 1'b1;
      @(posedge clock);
      #1;

      do_op("zero_act", 0, 64, 64, 0, 1'b0);
      do_op("mid_pos_y", 128, 128, 96, 0, 1'b0);
      do_op("mid_neg_y", -128, 128, 96, 0, 1'b0);
      do_op("neg_g", 128, -64, -48, 0, 1'b0);
      do_op("round_zero", 128, -1, 0, 0, 1'b0);
      do_op("sat_pos", 256, 100, 0, 0, 1'b0);
      do_op("sat_neg", -384, 100, 0, 0, 1'b0);
      do_op("sat_min", -512, -512, 0, 0, 1'b0);

      do_op("backpress", 0, -512, -512, 5, 1'b1);
      extra = 0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clock);
         #1;
         if (out_valid) extra++;
      end
      chk("no_extra_result", extra, 0);

      do_op("pre_reset", 128, 128, 96, 0, 1'b0);
      y        = 10'd0;
      g        = 10'd64;
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      repeat (11) @(posedge clock);
      #3;
      resetn = 1'b0;
      #1;
      chk("midrst_out", int'(out), 0);
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_in_ready", int'(in_ready), 1);
      @(posedge clock);
      #1;
      chk("midrst_hold_valid", int'(out_valid), 0);
      resetn = 1'b1;
      #1;
      do_op("after_rst", 0, 5, 5, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
      $finish;
   end

endmodule
